// File: rtl/prt_frame_writer.sv
// Ingress writer in front of the packet reference table. It claims a slot for each frame,
// streams the bytes into that slot, and queues a {slot, length} descriptor for the classifier.
module prt_frame_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLOTS  = 10,
  parameter int MAX_FRAME  = 1518,
  parameter int DESC_DEPTH = 4,
  localparam int SW = $clog2(NUM_SLOTS),
  localparam int LW = $clog2(MAX_FRAME + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  prt_slot_free,
  output logic                  prt_start_en,
  input  logic                  prt_start_rdy,
  input  logic [SW-1:0]         prt_start_slot,
  output logic                  prt_write_en,
  input  logic                  prt_write_rdy,
  output logic [DATA_WIDTH-1:0] prt_write_data,
  output logic                  prt_finish_en,
  input  logic                  prt_finish_rdy,
  output logic                  prt_inval_en,
  input  logic                  prt_inval_rdy,
  output logic [SW-1:0]         prt_inval_slot,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [SW-1:0]         d_slot,
  output logic [LW-1:0]         d_len,
  output logic [15:0]           drop_count
);
  // Handshakes: an item moves on a rising CLK edge where valid and ready are both 1.
  // Each PRT *_en strobe is raised only while its *_rdy is 1, so every strobe is a transfer.

  localparam int AW = $clog2(DESC_DEPTH);
  localparam int DDW = SW + LW;

  typedef enum logic [2:0] {IDLE, ALLOC, WRITE, FINISH, ABT_FIN, ABT_INV, DISCARD} state_t;
  state_t state_q, state_d;

  logic [LW-1:0]  len_q, len_inc;
  logic [SW-1:0]  slot_q;
  logic [15:0]    drop_q;
  logic [AW:0]    wr_ptr_q, rd_ptr_q;
  logic [DDW-1:0] mem_q [DESC_DEPTH];
  logic           fifo_empty, fifo_full, push, pop, byte_acc, start_ok;

  assign len_inc    = len_q + LW'(1);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign start_ok   = s_valid && prt_slot_free && prt_start_rdy && !fifo_full;
  assign byte_acc   = (state_q == WRITE) && s_valid && prt_write_rdy;
  assign push       = (state_q == FINISH) && prt_finish_rdy;
  assign pop        = !fifo_empty && d_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = ALLOC;
      ALLOC:   state_d = WRITE;
      WRITE: begin
        // The abort fires on the byte that reaches MAX_FRAME without s_last,
        // so a frame of exactly MAX_FRAME bytes still closes normally.
        if (byte_acc) begin
          if (s_last)                           state_d = FINISH;
          else if (len_inc == LW'(MAX_FRAME))   state_d = ABT_FIN;
        end
      end
      FINISH:  if (prt_finish_rdy) state_d = IDLE;
      ABT_FIN: if (prt_finish_rdy) state_d = ABT_INV;
      ABT_INV: if (prt_inval_rdy)  state_d = DISCARD;
      DISCARD: if (s_valid && s_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready        = 1'b0;
    prt_start_en   = 1'b0;
    prt_write_en   = 1'b0;
    prt_write_data = '0;
    prt_finish_en  = 1'b0;
    prt_inval_en   = 1'b0;
    case (state_q)
      // Gated by RST_N so that no enable can leak out while reset is held.
      IDLE:    prt_start_en = RST_N && start_ok;
      WRITE: begin
        s_ready        = prt_write_rdy;
        prt_write_en   = s_valid && prt_write_rdy;
        prt_write_data = s_data;
      end
      FINISH:  prt_finish_en = prt_finish_rdy;
      ABT_FIN: prt_finish_en = prt_finish_rdy;
      ABT_INV: prt_inval_en  = prt_inval_rdy;
      DISCARD: s_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_q  <= '0;
      slot_q <= '0;
      drop_q <= '0;
    end else begin
      if (state_q == ALLOC) begin
        slot_q <= prt_start_slot;
        len_q  <= '0;
      end else if (byte_acc) begin
        len_q <= len_inc;
      end
      if (state_q == ABT_INV && prt_inval_rdy && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DESC_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= {slot_q, len_q};
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  assign prt_inval_slot = slot_q;
  assign drop_count     = drop_q;
  assign d_valid        = !fifo_empty;
  assign d_slot         = mem_q[rd_ptr_q[AW-1:0]][DDW-1:LW];
  assign d_len          = mem_q[rd_ptr_q[AW-1:0]][LW-1:0];

endmodule

// File: tb/tb_prt_frame_writer.sv
// Bench for prt_frame_writer: a PRT responder, a byte-stream driver and a frame-level
// reference model whose expected writes, descriptors and drops are compared against a monitor.
`timescale 1ns/1ps
module tb_prt_frame_writer;
  localparam int DW   = 8;
  localparam int NS   = 10;
  localparam int MAXF = 1518;
  localparam int DD   = 4;
  localparam int SW   = $clog2(NS);
  localparam int LW   = $clog2(MAXF + 1);

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          prt_slot_free = 1'b1, prt_start_en, prt_start_rdy = 1'b1;
  logic [SW-1:0] prt_start_slot = '0;
  logic          prt_write_en, prt_write_rdy = 1'b1;
  logic [DW-1:0] prt_write_data;
  logic          prt_finish_en, prt_finish_rdy = 1'b1;
  logic          prt_inval_en, prt_inval_rdy = 1'b1;
  logic [SW-1:0] prt_inval_slot;
  logic          d_valid, d_ready = 1'b0;
  logic [SW-1:0] d_slot;
  logic [LW-1:0] d_len;
  logic [15:0]   drop_count;

  always #5 CLK = ~CLK;

  prt_frame_writer #(.DATA_WIDTH(DW), .NUM_SLOTS(NS), .MAX_FRAME(MAXF), .DESC_DEPTH(DD)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .prt_slot_free(prt_slot_free), .prt_start_en(prt_start_en), .prt_start_rdy(prt_start_rdy),
    .prt_start_slot(prt_start_slot),
    .prt_write_en(prt_write_en), .prt_write_rdy(prt_write_rdy), .prt_write_data(prt_write_data),
    .prt_finish_en(prt_finish_en), .prt_finish_rdy(prt_finish_rdy),
    .prt_inval_en(prt_inval_en), .prt_inval_rdy(prt_inval_rdy), .prt_inval_slot(prt_inval_slot),
    .d_valid(d_valid), .d_ready(d_ready), .d_slot(d_slot), .d_len(d_len),
    .drop_count(drop_count)
  );

  // Scoreboard state
  logic [DW-1:0]    exp_wr_q[$],   got_wr_q[$];
  logic [SW+LW-1:0] exp_desc_q[$], got_desc_q[$];
  logic [SW-1:0]    exp_inv_q[$],  got_inv_q[$];
  logic [SW-1:0]    slot_q[$];
  int n_checks = 0, n_errors = 0;
  int exp_drop = 0;
  int cyc = 0, n_start = 0, n_finish = 0, n_inval = 0, sready_cycles = 0, excl_viol = 0;
  int last_acc_cyc = 0, dv_rise_cyc = 0, fin_cyc = 0, inv_cyc = 0;
  logic dv_prev = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: samples 2ns after each rising edge, when inputs for this cycle are settled.
  always begin
    @(posedge CLK); #2;
    cyc++;
    if (RST_N) begin
      if (int'(prt_start_en) + int'(prt_write_en) + int'(prt_finish_en) + int'(prt_inval_en) > 1)
        excl_viol++;
      if (prt_start_en) begin
        n_start++;
        if (slot_q.size() > 0) prt_start_slot = slot_q.pop_front();
      end
      if (prt_write_en) got_wr_q.push_back(prt_write_data);
      if (prt_finish_en) begin n_finish++; fin_cyc = cyc; end
      if (prt_inval_en) begin n_inval++; inv_cyc = cyc; got_inv_q.push_back(prt_inval_slot); end
      if (s_ready) sready_cycles++;
      if (s_valid && s_ready && s_last) last_acc_cyc = cyc;
      if (d_valid && !dv_prev) dv_rise_cyc = cyc;
      if (d_valid && d_ready) got_desc_q.push_back({d_slot, d_len});
      dv_prev = d_valid;
    end else begin
      dv_prev = 1'b0;
    end
  end

  // Randomised PRT / consumer readiness
  always begin
    @(posedge CLK); #1;
    if (rand_rdy) begin
      prt_slot_free  = ($urandom_range(0, 3) != 0);
      prt_start_rdy  = ($urandom_range(0, 3) != 0);
      prt_write_rdy  = ($urandom_range(0, 3) != 0);
      prt_finish_rdy = ($urandom_range(0, 2) != 0);
      prt_inval_rdy  = ($urandom_range(0, 2) != 0);
      d_ready        = ($urandom_range(0, 1) != 0);
    end
  end

  task automatic settle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic set_all_rdy(input logic v);
    prt_slot_free = v; prt_start_rdy = v; prt_write_rdy = v;
    prt_finish_rdy = v; prt_inval_rdy = v;
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge that accepted the byte.
  task automatic drive_byte(input logic [DW-1:0] d, input logic last);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    #1;
    while (!s_ready && n < 20000) begin @(posedge CLK); #2; n++; end
    if (n >= 20000) check("byte_timeout", 1, 0);
    @(posedge CLK); #1;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
  endtask

  // Reference model: the first MAXF bytes reach the PRT; a frame within MAXF yields a
  // descriptor, a longer one is invalidated and counted as a drop.
  task automatic send_frame(input int len, input logic [SW-1:0] slot, input bit gaps, input bit ramp);
    logic [DW-1:0] b;
    slot_q.push_back(slot);
    for (int i = 0; i < len; i++) begin
      b = ramp ? DW'(i) : DW'($urandom);
      if (i < MAXF) exp_wr_q.push_back(b);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      drive_byte(b, i == len - 1);
    end
    if (len <= MAXF) exp_desc_q.push_back({slot, LW'(len)});
    else begin
      exp_inv_q.push_back(slot);
      if (exp_drop < 16'hFFFF) exp_drop++;
    end
  endtask

  task automatic compare_sb(input string tag);
    int bad = 0;
    check({tag, "_wr_n"}, got_wr_q.size(), exp_wr_q.size());
    for (int i = 0; i < got_wr_q.size() && i < exp_wr_q.size(); i++)
      if (got_wr_q[i] !== exp_wr_q[i]) bad++;
    check({tag, "_wr_data_bad"}, bad, 0);
    check({tag, "_desc_n"}, got_desc_q.size(), exp_desc_q.size());
    for (int i = 0; i < got_desc_q.size() && i < exp_desc_q.size(); i++)
      check({tag, "_desc"}, got_desc_q[i], exp_desc_q[i]);
    check({tag, "_inv_n"}, got_inv_q.size(), exp_inv_q.size());
    for (int i = 0; i < got_inv_q.size() && i < exp_inv_q.size(); i++)
      check({tag, "_inv_slot"}, got_inv_q[i], exp_inv_q[i]);
    check({tag, "_drop"}, drop_count, exp_drop);
    got_wr_q.delete(); exp_wr_q.delete(); got_desc_q.delete(); exp_desc_q.delete();
    got_inv_q.delete(); exp_inv_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_start_en"}, prt_start_en, 0);
    check({tag, "_write_en"}, prt_write_en, 0);
    check({tag, "_write_data"}, prt_write_data, 0);
    check({tag, "_finish_en"}, prt_finish_en, 0);
    check({tag, "_inval_en"}, prt_inval_en, 0);
    check({tag, "_inval_slot"}, prt_inval_slot, 0);
    check({tag, "_d_valid"}, d_valid, 0);
    check({tag, "_d_slot"}, d_slot, 0);
    check({tag, "_d_len"}, d_len, 0);
    check({tag, "_drop"}, drop_count, 0);
  endtask

  initial begin
    int s0, f0, i0, r0, n;
    // Reset with an eager source and a fully ready PRT: nothing may escape.
    s_valid = 1'b1; s_data = 8'hA5; set_all_rdy(1'b1);
    @(posedge CLK); #1;
    check_outputs_zero("reset");
    s_valid = 1'b0; s_data = '0;
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    check("post_reset_d_valid", d_valid, 0);

    // Single frame, slot 3, bytes 0..4
    f0 = n_finish;
    send_frame(5, 3, 1'b0, 1'b1);
    settle(4);
    check("single_latency", dv_rise_cyc - last_acc_cyc, 2);
    check("single_finish_n", n_finish - f0, 1);
    check("single_d_valid", d_valid, 1);
    check("single_d_slot", d_slot, 3);
    check("single_d_len", d_len, 5);
    d_ready = 1'b1; settle(2); d_ready = 1'b0;
    compare_sb("single");

    // Back-pressure: no free slot for 20 cycles
    prt_slot_free = 1'b0; s_valid = 1'b1; s_data = 8'h11;
    s0 = n_start; r0 = sready_cycles;
    settle(20);
    check("bp_start_en", n_start - s0, 0);
    check("bp_s_ready", sready_cycles - r0, 0);
    prt_slot_free = 1'b1; d_ready = 1'b1;
    send_frame(6, 8, 1'b0, 1'b0);
    settle(5);
    compare_sb("bp");

    // Oversize: 1600 bytes into slot 7
    f0 = n_finish; i0 = n_inval;
    send_frame(1600, 7, 1'b0, 1'b0);
    settle(5);
    check("over_finish_n", n_finish - f0, 1);
    check("over_inval_n", n_inval - i0, 1);
    check("over_inval_after_finish", inv_cyc > fin_cyc, 1);
    compare_sb("over");

    // Boundary: exactly MAXF bytes is legal
    i0 = n_inval;
    send_frame(MAXF, 2, 1'b0, 1'b0);
    settle(5);
    check("bound_inval_n", n_inval - i0, 0);
    compare_sb("bound");

    // Descriptor FIFO full: fifth frame must wait for a pop
    d_ready = 1'b0; s0 = n_start;
    send_frame(3, 0, 1'b0, 1'b0);
    send_frame(3, 1, 1'b0, 1'b0);
    send_frame(3, 2, 1'b0, 1'b0);
    send_frame(3, 4, 1'b0, 1'b0);
    settle(4);
    check("full_d_valid", d_valid, 1);
    check("full_popped", got_desc_q.size(), 0);
    check("full_start_n", n_start - s0, 4);
    fork
      send_frame(3, 5, 1'b0, 1'b0);
      begin
        settle(10);
        check("full_stall_start", n_start - s0, 4);
        d_ready = 1'b1; settle(1); d_ready = 1'b0;
      end
    join
    settle(4);
    check("full_after_start", n_start - s0, 5);
    d_ready = 1'b1; settle(8);
    compare_sb("full");

    // Asynchronous reset in the middle of a frame
    slot_q.push_back(6);
    drive_byte(8'hAA, 1'b0);
    drive_byte(8'hBB, 1'b0);
    s_valid = 1'b1; s_data = 8'hCC;
    #2 RST_N = 1'b0;
    #1 check_outputs_zero("midreset");
    s_valid = 1'b0; s_data = '0;
    got_wr_q.delete(); exp_wr_q.delete(); got_desc_q.delete(); exp_desc_q.delete();
    got_inv_q.delete(); exp_inv_q.delete(); slot_q.delete();
    exp_drop = 0;
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    send_frame(3, 9, 1'b0, 1'b0);
    settle(5);
    compare_sb("after_reset");

    // Randomised traffic with random PRT and consumer readiness
    rand_rdy = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (k == 12) send_frame(MAXF + int'($urandom_range(1, 4)), SW'($urandom_range(0, NS-1)), 1'b1, 1'b0);
      else         send_frame(int'($urandom_range(1, 40)), SW'($urandom_range(0, NS-1)), 1'b1, 1'b0);
    end
    settle(1);
    rand_rdy = 1'b0;
    set_all_rdy(1'b1); d_ready = 1'b1;
    n = 0;
    settle(6);
    while (d_valid && n < 50) begin settle(1); n++; end
    check("rand_drain", d_valid, 0);
    compare_sb("rand");

    check("enables_exclusive", excl_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prt_frame_writer.md
Name: prt_frame_writer

Overview:
- Ingress stage directly upstream of the PRT (packet reference table).
- Accepts a byte stream of received frames, claims a free PRT slot, writes each byte into it, and closes the entry on the final byte.
- For every completed frame, pushes a descriptor {slot, length} into an internal FIFO, which the downstream classifier consumes.
- Oversized frames are released back to the PRT and discarded.

Parameters:
- DATA_WIDTH, 8: stream and PRT byte width.
- NUM_SLOTS, 10: number of PRT slots; slot field width is SW = $clog2(NUM_SLOTS).
- MAX_FRAME, 1518: largest legal frame in bytes; length field width is LW = $clog2(MAX_FRAME+1).
- DESC_DEPTH, 4: depth of the descriptor FIFO, power of two.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous, active-low.
- s_valid  in  1  byte valid.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- s_data  in  DATA_WIDTH  frame byte.
- s_last  in  1  final byte of the frame.
- prt_slot_free  in  1  PRT has a free slot.
- prt_start_en  out  1  PRT start_writing enable.
- prt_start_rdy  in  1  PRT start_writing ready.
- prt_start_slot  in  SW  slot allocated by the PRT; valid in the cycle after prt_start_en.
- prt_write_en  out  1  PRT write enable.
- prt_write_rdy  in  1  PRT write ready.
- prt_write_data  out  DATA_WIDTH  byte to the PRT.
- prt_finish_en  out  1  PRT finish_writing enable.
- prt_finish_rdy  in  1  PRT finish ready.
- prt_inval_en  out  1  PRT invalidate enable.
- prt_inval_rdy  in  1  PRT invalidate ready.
- prt_inval_slot  out  SW  slot to invalidate.
- d_valid  out  1  descriptor available (FIFO not empty).
- d_ready  in  1  descriptor consumed.
- d_slot  out  SW  descriptor slot.
- d_len  out  LW  descriptor byte count.
- drop_count  out  16  oversized frames dropped; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release): FSM returns to IDLE; len, slot register, FIFO pointers and drop_count clear to 0. All outputs read 0 during reset.
- Reset mid-frame abandons the frame; the PRT shares the same reset.
- FSM states: IDLE, ALLOC, WRITE, FINISH, ABT_FIN, ABT_INV, DISCARD.
- IDLE: s_ready=0. When s_valid && prt_slot_free && prt_start_rdy && FIFO not full:
  - prt_start_en=1 for exactly one cycle;
  - go to ALLOC.
  - Otherwise hold. Missing a slot or a full FIFO applies back-pressure; it never causes a drop.
- ALLOC: s_ready=0; slot register <= prt_start_slot; len <= 0; go to WRITE. The first byte is therefore accepted no earlier than 2 cycles after leaving IDLE.
- WRITE: s_ready = prt_write_rdy.
  - prt_write_en = s_valid && prt_write_rdy; prt_write_data = s_data (combinational, same cycle).
  - Each accepted byte does len <= len+1.
  - Accepted byte with s_last=1 and new length <= MAX_FRAME: go to FINISH.
  - Accepted byte with s_last=0 and new length == MAX_FRAME: go to ABT_FIN.
- FINISH: s_ready=0. In the cycle prt_finish_rdy=1:
  - prt_finish_en=1;
  - push {slot, len} into the FIFO;
  - go to IDLE.
  - The FIFO has room because it was checked in IDLE and only this FSM pushes.
- ABT_FIN: prt_finish_en=1 when prt_finish_rdy; then go to ABT_INV.
- ABT_INV: prt_inval_slot = slot; prt_inval_en=1 when prt_inval_rdy; drop_count++ (saturating); go to DISCARD.
- DISCARD: s_ready=1; bytes are consumed and not written. An accepted s_last goes to IDLE.
- A frame of exactly MAX_FRAME bytes with s_last on the final byte is legal.
- Enables (start/write/finish/inval) are never asserted together.
- Descriptor FIFO: DESC_DEPTH entries.
  - d_valid = !empty; d_slot/d_len show the head entry.
  - Pop on d_valid && d_ready.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Pointers wrap modulo DESC_DEPTH; full = DESC_DEPTH entries held.
- Latency: last byte accepted in cycle N; d_valid rises in cycle N+2 (FIFO empty, prt_finish_rdy=1).

Test Plan:
- Single frame: 5 bytes 0..4, PRT grants slot 3 -> 5 write pulses carrying 0..4 in order; one finish pulse; descriptor {3,5}; d_valid 2 cycles after the last byte.
- Back-pressure: prt_slot_free=0 while s_valid=1 for 20 cycles -> s_ready stays 0 and prt_start_en stays 0. Release -> frame written intact; drop_count=0.
- Oversize: 1600-byte frame with s_last on byte 1600 ->
  - exactly 1518 write pulses;
  - finish, then invalidate of the granted slot;
  - remaining 82 bytes consumed;
  - no descriptor; drop_count=1.
- Boundary: 1518-byte frame with s_last on byte 1518 -> descriptor {slot,1518}; no invalidate.
- FIFO full: d_ready=0 and 4 frames of 3 bytes -> 4 descriptors held. A 5th frame stalls in IDLE with no prt_start_en. One pop -> 5th frame proceeds; descriptor order is preserved.
- Async reset mid-WRITE after 2 bytes -> all outputs 0 immediately. After release, a new 3-byte frame -> descriptor length 3.
